br_pred_ctrl: RTL and testbench
===============================

Name: br_pred_ctrl

Overview:
- Branch prediction controller feeding br_alu: gshare 2-bit-counter BHT, predicted-target generation at fetch, in-flight prediction queue.
- IF looks up PC/IR and receives taken/target; EX resolves oldest branch against the queue head (pr_taken to br_alu), trains the BHT, counts mispredicts.
- Sits between fetch PC mux and br_alu; `flush` from hazard/trap logic.

Parameters:
- IDX_BITS, 6, BHT index width; 2**IDX_BITS counters.
- GHR_BITS, 6, global history length; must be <= IDX_BITS.
- QDEPTH, 4, in-flight branch queue depth; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- lu_valid  in  1  fetch presents instruction
- lu_pc  in  64  instruction PC
- lu_ir  in  32  instruction word
- lu_ready  out  1  queue can accept a branch (!full)
- lu_taken  out  1  prediction for lu_ir (0 if not a branch)
- lu_target  out  64  lu_pc + B-imm if lu_taken, else lu_pc + 4
- rs_valid  in  1  EX resolves a conditional branch this cycle
- rs_taken  in  1  actual outcome (br_alu brc)
- pr_taken  out  1  head-of-queue prediction to br_alu; 0 when empty
- flush  in  1  discard all in-flight predictions
- br_cnt  out  32  resolved-branch counter
- miss_cnt  out  32  mispredict counter

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Branch detect: lu_ir[6:0]==7'b1100011. B-imm = sign-extended {ir[31],ir[7],ir[30:25],ir[11:8],1'b0}, 64-bit add, wraps mod 2^64.
- Index = lu_pc[IDX_BITS+1:2] XOR zero-extended ghr.
- Lookup is combinational. lu_taken = counter[index][1] & is_branch & lu_valid.
- Push: lu_valid & is_branch & lu_ready pushes {lu_taken, index}. A non-branch never pushes. A push while full is dropped; fetch must stall on !lu_ready.
- Pop: rs_valid & !empty pops the head.
  - Head counter saturating update: +1 if rs_taken (max 3), -1 otherwise (min 0).
  - ghr <= {ghr[GHR_BITS-2:0], rs_taken}.
  - br_cnt +1; miss_cnt +1 if head.taken != rs_taken.
  - rs_valid on an empty queue is ignored: no update, no count.
- pr_taken = head.taken when !empty, else 0. Combinational from queue registers.
- Simultaneous push and pop: both happen; occupancy unchanged; a full queue stays full and accepts the push only if the pop frees a slot in the same cycle. lu_ready itself stays !full.
- Same-cycle lookup and update of the same counter: lookup sees the pre-update value; write lands at clock edge.
- Flush: queue pointers/count -> 0 next cycle. A same-cycle push is dropped. A same-cycle pop still trains the BHT and bumps counters. GHR is not reverted (non-speculative history).
- Pointer wrap: log2(QDEPTH) pointers wrap naturally; occupancy count 0..QDEPTH.
- Counters wrap mod 2^32.
- Reset values:
  - All BHT entries 2'b01 (weakly not-taken).
  - ghr=0; queue empty; br_cnt=miss_cnt=0.
  - Resulting outputs: pr_taken=0, lu_ready=1, lu_taken=0.
- Reset mid-operation overrides all; in-flight entries are lost.

Decomposition:
- Shared package: OP_BRANCH (7'b1100011) and B-imm extraction function, also used by br_alu.
- Single sub-module `bp_queue`: parametric FIFO with push/pop/flush/full/empty/head. BHT, GHR and counters stay in the top.

Test Plan:
- Reset, then lu_valid with ir=beq (+16) at pc=0x1000 -> lu_taken=0, lu_target=0x1004, pr_taken=0 next cycle from queue head.
- Same branch resolved taken twice, ghr forced constant by alternating nothing else -> third lookup at the same index gives lu_taken=1, lu_target=0x1010.
- Backward branch imm=-8 at pc=0x0 predicted taken -> lu_target=0xFFFF_FFFF_FFFF_FFF8.
- Push 4 branches without resolve -> lu_ready=0; 5th push dropped. Pop+push same cycle keeps count=4. Then flush -> empty, pr_taken=0, lu_ready=1.
- Predicted not-taken, resolved taken -> miss_cnt=1, br_cnt=1, ghr LSB=1. rs_valid on empty queue -> counts unchanged.
- Counter saturation: 5 taken resolutions on one index -> counter 3; one not-taken -> 2, still predicts taken.

Source files
------------

// File: rtl/br_pred_ctrl_pkg.sv
// br_pred_ctrl_pkg: branch opcode and B-type immediate decode shared with br_alu
package br_pred_ctrl_pkg;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   function automatic logic [63:0] b_imm(input logic [31:0] ir);
      return {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction
endpackage

// File: rtl/bp_queue.sv
// bp_queue: in-flight prediction FIFO; a pop frees room for a same-cycle push when full
module bp_queue #(
   parameter int W     = 7,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push, w_pop;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign o_head  = r_mem[r_rp];
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop) & ~i_flush;
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_push);
         r_rp  <= r_rp + AW'(w_pop);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/br_pred_ctrl.sv
// br_pred_ctrl: gshare 2-bit BHT predictor with fetch-time target and in-flight queue
module br_pred_ctrl
   import br_pred_ctrl_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int GHR_BITS = 6,
   parameter int QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lu_valid,
   input  logic [63:0] lu_pc,
   input  logic [31:0] lu_ir,
   output logic        lu_ready,
   output logic        lu_taken,
   output logic [63:0] lu_target,
   input  logic        rs_valid,
   input  logic        rs_taken,
   output logic        pr_taken,
   input  logic        flush,
   output logic [31:0] br_cnt,
   output logic [31:0] miss_cnt
);
   logic [1:0]          r_bht [2**IDX_BITS];
   logic [GHR_BITS-1:0] r_ghr;
   logic [31:0]         r_br_cnt, r_miss_cnt;
   logic                w_is_br, w_full, w_empty, w_pop, w_unused;
   logic [IDX_BITS-1:0] w_idx, w_hidx;
   logic [IDX_BITS:0]   w_head;
   logic [1:0]          w_ctr, w_ctr_nxt;
   assign w_is_br   = lu_ir[6:0] == OP_BRANCH;
   assign w_idx     = lu_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
   assign lu_taken  = r_bht[w_idx][1] & w_is_br & lu_valid;
   assign lu_target = lu_pc + (lu_taken ? b_imm(lu_ir) : 64'd4);
   assign lu_ready  = ~w_full;
   assign pr_taken  = ~w_empty & w_head[IDX_BITS];
   assign w_pop     = rs_valid & ~w_empty;
   assign w_hidx    = w_head[IDX_BITS-1:0];
   assign w_ctr     = r_bht[w_hidx];
   assign w_ctr_nxt = rs_taken ? (w_ctr == 2'b11 ? w_ctr : w_ctr + 2'd1)
                               : (w_ctr == 2'b00 ? w_ctr : w_ctr - 2'd1);
   assign br_cnt    = r_br_cnt;
   assign miss_cnt  = r_miss_cnt;
   assign w_unused  = ^lu_ir[24:12];
   bp_queue #(.W(IDX_BITS+1), .DEPTH(QDEPTH)) u_q (
      .clk     (clk),
      .rst     (rst),
      .i_push  (lu_valid & w_is_br),
      .i_pop   (rs_valid),
      .i_flush (flush),
      .i_data  ({lu_taken, w_idx}),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   // history is trained only at resolve, so a flush never has to rewind it
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**IDX_BITS; i++) r_bht[i] <= 2'b01;
         r_ghr      <= '0;
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else if (w_pop) begin
         r_bht[w_hidx] <= w_ctr_nxt;
         r_ghr         <= {r_ghr[GHR_BITS-2:0], rs_taken};
         r_br_cnt      <= r_br_cnt + 32'd1;
         r_miss_cnt    <= r_miss_cnt + 32'(w_head[IDX_BITS] != rs_taken);
      end
   end
endmodule

// File: tb/tb_br_pred_ctrl.sv
// tb_br_pred_ctrl: directed plus random checks against a queue-based gshare model
module tb_br_pred_ctrl;
   localparam int QD = 4;
   logic        clk = 0, rst, lu_valid, rs_valid, rs_taken, flush;
   logic [63:0] lu_pc;
   logic [31:0] lu_ir;
   logic        lu_ready, lu_taken, pr_taken;
   logic [63:0] lu_target;
   logic [31:0] br_cnt, miss_cnt;
   int n_cmp = 0, n_err = 0;
   typedef struct {bit taken; int idx;} ent_t;
   ent_t        mq[$];
   int          m_bht[64];
   int          m_ghr;
   bit [31:0]   m_br, m_miss;

   br_pred_ctrl dut (
      .clk(clk), .rst(rst), .lu_valid(lu_valid), .lu_pc(lu_pc), .lu_ir(lu_ir),
      .lu_ready(lu_ready), .lu_taken(lu_taken), .lu_target(lu_target),
      .rs_valid(rs_valid), .rs_taken(rs_taken), .pr_taken(pr_taken), .flush(flush),
      .br_cnt(br_cnt), .miss_cnt(miss_cnt)
   );
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_b(int imm, int rs);
      logic [12:0] i = 13'(imm);
      return {i[12], i[10:5], 5'(rs), 5'(rs + 3), 3'b000, i[4:1], i[11], 7'b1100011};
   endfunction

   function automatic int m_idx();
      return int'(lu_pc[7:2]) ^ m_ghr;
   endfunction

   function automatic bit m_isbr();
      return lu_ir[6:0] == 7'b1100011;
   endfunction

   function automatic bit m_pred();
      return lu_valid && m_isbr() && m_bht[m_idx()] >= 2;
   endfunction

   function automatic logic [63:0] m_target();
      int off;
      off = $signed({lu_ir[31], lu_ir[7], lu_ir[30:25], lu_ir[11:8], 1'b0});
      return m_pred() ? lu_pc + 64'(signed'(off)) : lu_pc + 64'd4;
   endfunction

   task automatic m_reset();
      foreach (m_bht[i]) m_bht[i] = 1;
      m_ghr = 0; m_br = 0; m_miss = 0;
      mq.delete();
   endtask

   task automatic drive(bit v, logic [63:0] pc, logic [31:0] ir, bit rv, bit rt, bit fl);
      lu_valid = v; lu_pc = pc; lu_ir = ir; rs_valid = rv; rs_taken = rt; flush = fl;
   endtask

   task automatic cyc();
      bit   p, full, pop, push;
      int   ix;
      ent_t e;
      @(negedge clk);
      chk("lu_ready", lu_ready, mq.size() != QD);
      chk("lu_taken", lu_taken, m_pred());
      chk("lu_target", lu_target, m_target());
      chk("pr_taken", pr_taken, mq.size() != 0 && mq[0].taken);
      chk("br_cnt", br_cnt, m_br);
      chk("miss_cnt", miss_cnt, m_miss);
      p = m_pred(); ix = m_idx();
      full = mq.size() == QD;
      pop  = rs_valid && mq.size() != 0;
      push = lu_valid && m_isbr() && (!full || pop) && !flush;
      if (rst) m_reset();
      else begin
         if (pop) begin
            e = mq.pop_front();
            m_bht[e.idx] = rs_taken ? (m_bht[e.idx] == 3 ? 3 : m_bht[e.idx] + 1)
                                    : (m_bht[e.idx] == 0 ? 0 : m_bht[e.idx] - 1);
            m_ghr = ((m_ghr << 1) | int'(rs_taken)) & 63;
            m_br++;
            if (e.taken != rs_taken) m_miss++;
         end
         if (flush) mq.delete();
         else if (push) mq.push_back('{p, ix});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      m_reset();
      rst = 1; drive(0, 0, 0, 0, 0, 0);
      cyc(); cyc();
      rst = 0;
      chk("reset_ready", lu_ready, 1'b1);
      chk("reset_pr", pr_taken, 1'b0);
      drive(1, 64'h1000, enc_b(16, 1), 0, 0, 0); #1;
      chk("first_taken", lu_taken, 1'b0);
      chk("first_target", lu_target, 64'h1004);
      cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("first_pr", pr_taken, 1'b0);
      drive(0, 0, 0, 1, 1, 0); cyc();
      chk("miss_one", miss_cnt, 32'd1);
      chk("br_one", br_cnt, 32'd1);
      drive(0, 0, 0, 1, 0, 0); cyc();
      chk("empty_rs_br", br_cnt, 32'd1);
      chk("empty_rs_miss", miss_cnt, 32'd1);
      // saturate history to all-ones so pc 0 always indexes entry 63
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, enc_b(-8, k), 0, 0, 0); cyc();
         drive(0, 0, 0, 1, 1, 0); cyc();
      end
      drive(1, 0, enc_b(-8, 2), 0, 0, 0); #1;
      chk("back_taken", lu_taken, 1'b1);
      chk("back_target", lu_target, 64'hFFFF_FFFF_FFFF_FFF8);
      cyc();
      drive(0, 0, 0, 1, 0, 0); cyc();
      for (int k = 0; k < 4; k++) begin
         drive(1, 64'h2000 + 64'(k * 4), enc_b(32, k), 0, 0, 0); cyc();
      end
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("full_ready", lu_ready, 1'b0);
      drive(1, 64'h3000, enc_b(8, 5), 0, 0, 0); cyc();
      drive(1, 64'h3004, enc_b(8, 6), 1, 1, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("swap_ready", lu_ready, 1'b0);
      drive(1, 64'h3008, enc_b(8, 7), 1, 0, 1); cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("flush_pr", pr_taken, 1'b0);
      chk("flush_ready", lu_ready, 1'b1);
      for (int k = 0; k < 400; k++) begin
         logic [31:0] ir;
         ir = $urandom_range(0, 2) != 0 ? enc_b(int'($urandom_range(0, 4095)) * 2 - 4096, k)
                                        : {$urandom() & 32'hFFFF_FF80, 7'b0010011};
         rst = $urandom_range(0, 199) == 0;
         drive($urandom_range(0, 3) != 0, {$urandom(), $urandom_range(0, 63), 2'b00}, ir,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
         cyc();
      end
      rst = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
